// File: rtl/controle_pkg.sv
// Shared codes for the controle_seq sequencer.
// The CONTROLE_MUL_EN macro adds the MUL states.
package controle_pkg;

   localparam logic [1:0] T_CLR  = 2'b00;
   localparam logic [1:0] T_HOLD = 2'b01;
   localparam logic [1:0] T_LOAD = 2'b10;

   localparam int ULA_ADD = 0;
   localparam int ULA_SUB = 1;
   localparam int ULA_SR  = 2;
   localparam int ULA_SL  = 3;

   typedef enum logic [2:0] {
      OP_CLR_LDX = 3'd0,
      OP_ADD     = 3'd1,
      OP_SUB     = 3'd2,
      OP_SR      = 3'd3,
      OP_SL      = 3'd4,
      OP_DISP    = 3'd5,
      OP_MUL     = 3'd6,
      OP_RSV     = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      K_EXEC = 2'd0,
      K_DISP = 2'd1,
      K_MUL  = 2'd2,
      K_ILL  = 2'd3
   } kind_e;

`ifdef CONTROLE_MUL_EN
   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_EXEC     = 3'd1,
      S_MUL_CLR  = 3'd2,
      S_MUL_LOOP = 3'd3,
      S_DISP     = 3'd4,
      S_FIN      = 3'd5
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_EXEC = 3'd1,
      S_DISP = 3'd4,
      S_FIN  = 3'd5
   } state_e;
`endif

endpackage

// File: rtl/controle_dec.sv
// Combinational opcode decoder: EXEC control vector plus path class.
// Opcode 6 decodes as MUL only when CONTROLE_MUL_EN is defined.
module controle_dec
   import controle_pkg::*;
#(
   parameter int INSTR_W = 3,
   parameter int ULA_W   = 3
) (
   input  logic [INSTR_W-1:0] op_i,
   output logic [1:0]         tx_o,
   output logic [1:0]         ty_o,
   output logic [1:0]         tz_o,
   output logic [ULA_W-1:0]   tula_o,
   output logic [1:0]         kind_o
);

   logic hi_zero;
   op_e  op;

   // Opcodes are zero-extended: any set upper bit is illegal.
   if (INSTR_W > 3) begin : g_hi
      assign hi_zero = ~|op_i[INSTR_W-1:3];
   end else begin : g_nohi
      assign hi_zero = 1'b1;
   end

   assign op = op_e'(op_i[2:0]);

   always_comb begin
      tx_o   = T_HOLD;
      ty_o   = T_HOLD;
      tz_o   = T_HOLD;
      tula_o = ULA_W'(ULA_ADD);
      kind_o = K_ILL;
      if (hi_zero) begin
         unique case (op)
            OP_CLR_LDX: begin
               tx_o   = T_LOAD;
               ty_o   = T_CLR;
               tz_o   = T_CLR;
               kind_o = K_EXEC;
            end
            OP_ADD, OP_SUB, OP_SR, OP_SL: begin
               tz_o   = T_LOAD;
               tula_o = ULA_W'(op_i[2:0] - 3'd1);
               kind_o = K_EXEC;
            end
            OP_DISP: kind_o = K_DISP;
`ifdef CONTROLE_MUL_EN
            OP_MUL:  kind_o = K_MUL;
`else
            OP_MUL:  kind_o = K_ILL;
`endif
            OP_RSV:  kind_o = K_ILL;
            default: kind_o = K_ILL;
         endcase
      end
   end

endmodule

// File: rtl/controle_seq.sv
// Instruction sequencer driving X/Y/Z register and ALU controls.
// Define CONTROLE_MUL_EN to enable the MUL opcode (6).
module controle_seq
   import controle_pkg::*;
#(
   parameter int INSTR_W  = 3,
   parameter int ULA_W    = 3,
   parameter int CNT_W    = 4,
   parameter int DISP_CYC = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instrucao,
   input  logic [CNT_W-1:0]   mul_count,
   output logic [1:0]         tx,
   output logic [1:0]         ty,
   output logic [1:0]         tz,
   output logic [ULA_W-1:0]   tula,
   output logic               disp_en,
   output logic               done,
   output logic               err
);

   localparam int DISP_W = $clog2(DISP_CYC + 1);
   localparam int CTR_W  = (CNT_W > DISP_W) ? CNT_W : DISP_W;
   localparam logic [CTR_W-1:0] ONE = CTR_W'(1);

   state_e             state_q, state_d;
   logic [CTR_W-1:0]   cnt_q, cnt_d;
   logic               ill_q, ill_d;
   logic [1:0]         tx_q, tx_d, ty_q, ty_d, tz_q, tz_d;
   logic [ULA_W-1:0]   tula_q, tula_d;
   logic               disp_q, disp_d;
   logic               done_q, done_d;
   logic               err_q, err_d;
   logic               rdy_q, rdy_d;

   logic [1:0]         dtx, dty, dtz;
   logic [ULA_W-1:0]   dtula;
   logic [1:0]         dkind;
   logic               accept;

   controle_dec #(
      .INSTR_W (INSTR_W),
      .ULA_W   (ULA_W)
   ) u_dec (
      .op_i   (instrucao),
      .tx_o   (dtx),
      .ty_o   (dty),
      .tz_o   (dtz),
      .tula_o (dtula),
      .kind_o (dkind)
   );

`ifndef CONTROLE_MUL_EN
   logic unused_mul;
   assign unused_mul = ^mul_count;
`endif

   assign accept = instr_valid & rdy_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ill_q   <= 1'b0;
         tx_q    <= T_HOLD;
         ty_q    <= T_HOLD;
         tz_q    <= T_HOLD;
         tula_q  <= ULA_W'(ULA_ADD);
         disp_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ill_q   <= ill_d;
         tx_q    <= tx_d;
         ty_q    <= ty_d;
         tz_q    <= tz_d;
         tula_q  <= tula_d;
         disp_q  <= disp_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
      end
   end

   // Illegal opcodes take the EXEC slot with a hold vector, so they
   // complete with the same two-cycle latency as ordinary opcodes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ill_d   = ill_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               ill_d = (dkind == K_ILL);
               unique case (dkind)
                  K_DISP: begin
                     state_d = S_DISP;
                     cnt_d   = CTR_W'(DISP_CYC);
                  end
`ifdef CONTROLE_MUL_EN
                  K_MUL: begin
                     state_d = S_MUL_CLR;
                     cnt_d   = CTR_W'(mul_count);
                  end
`endif
                  default: state_d = S_EXEC;
               endcase
            end
         end
         S_EXEC: state_d = S_FIN;
         S_DISP: begin
            if (cnt_q <= ONE) state_d = S_FIN;
            else cnt_d = cnt_q - ONE;
         end
`ifdef CONTROLE_MUL_EN
         S_MUL_CLR: begin
            if (cnt_q == '0) state_d = S_FIN;
            else state_d = S_MUL_LOOP;
         end
         S_MUL_LOOP: begin
            if (cnt_q <= ONE) state_d = S_FIN;
            else cnt_d = cnt_q - ONE;
         end
`endif
         S_FIN: begin
            state_d = S_IDLE;
            ill_d   = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs follow the upcoming state so they register with it.
   always_comb begin
      tx_d   = T_HOLD;
      ty_d   = T_HOLD;
      tz_d   = T_HOLD;
      tula_d = ULA_W'(ULA_ADD);
      disp_d = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
      rdy_d  = 1'b0;
      unique case (state_d)
         S_IDLE: rdy_d = 1'b1;
         S_EXEC: begin
            tx_d   = dtx;
            ty_d   = dty;
            tz_d   = dtz;
            tula_d = dtula;
         end
         S_DISP: disp_d = 1'b1;
`ifdef CONTROLE_MUL_EN
         S_MUL_CLR:  tz_d = T_CLR;
         S_MUL_LOOP: tz_d = T_LOAD;
`endif
         S_FIN: begin
            done_d = 1'b1;
            err_d  = ill_d;
         end
         default: ;
      endcase
   end

   assign instr_ready = rdy_q;
   assign tx          = tx_q;
   assign ty          = ty_q;
   assign tz          = tz_q;
   assign tula        = tula_q;
   assign disp_en     = disp_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_controle_seq.sv
// Directed plus randomized bench for controle_seq.
// Follows CONTROLE_MUL_EN to choose the expected opcode-6 behaviour.
module tb_controle_seq;

   localparam int INSTR_W  = 3;
   localparam int ULA_W    = 3;
   localparam int CNT_W    = 4;
   localparam int DISP_CYC = 4;

`ifdef CONTROLE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   // {tx, ty, tz, tula, disp_en}
   localparam logic [9:0] IDLE_V = {2'b01, 2'b01, 2'b01, 3'd0, 1'b0};

   logic               clock = 1'b0;
   logic               reset_n;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instrucao;
   logic [CNT_W-1:0]   mul_count;
   logic [1:0]         tx, ty, tz;
   logic [ULA_W-1:0]   tula;
   logic               disp_en, done, err;
   logic [9:0]         obs_v;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   controle_seq #(
      .INSTR_W  (INSTR_W),
      .ULA_W    (ULA_W),
      .CNT_W    (CNT_W),
      .DISP_CYC (DISP_CYC)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instrucao   (instrucao),
      .mul_count   (mul_count),
      .tx          (tx),
      .ty          (ty),
      .tz          (tz),
      .tula        (tula),
      .disp_en     (disp_en),
      .done        (done),
      .err         (err)
   );

   assign obs_v = {tx, ty, tz, tula, disp_en};

   function automatic bit is_ill(int op);
      return (op == 7) || (op == 6 && !MUL_ON);
   endfunction

   function automatic int lat_of(int op, int cnt);
      if (op == 5) return DISP_CYC + 1;
      if (op == 6 && MUL_ON) return cnt + 2;
      return 2;
   endfunction

   // Expected output vector k cycles after accept.
   function automatic logic [9:0] exp_vec(int op, int cnt, int k);
      if (k >= lat_of(op, cnt)) return IDLE_V;
      if (is_ill(op)) return IDLE_V;
      if (op == 0) return {2'b10, 2'b00, 2'b00, 3'd0, 1'b0};
      if (op <= 4) return {2'b01, 2'b01, 2'b10, 3'(op - 1), 1'b0};
      if (op == 5) return {2'b01, 2'b01, 2'b01, 3'd0, 1'b1};
      if (k == 1) return {2'b01, 2'b01, 2'b00, 3'd0, 1'b0};
      return {2'b01, 2'b01, 2'b10, 3'd0, 1'b0};
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge, idle.
   task automatic run_instr(int op, int cnt);
      int lat;
      lat         = lat_of(op, cnt);
      instr_valid = 1'b1;
      instrucao   = 3'(op);
      mul_count   = 4'(cnt);
      chk("ready_idle", 32'(instr_ready), 1);
      @(posedge clock);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clock);
         instr_valid = 1'($urandom_range(0, 1));
         instrucao   = 3'($urandom);
         mul_count   = 4'($urandom);
         chk("vec", 32'(obs_v), 32'(exp_vec(op, cnt, k)));
         chk("done", 32'(done), 32'(k == lat));
         chk("err", 32'(err), 32'((k == lat) && is_ill(op)));
         chk("ready_busy", 32'(instr_ready), 0);
      end
      @(negedge clock);
      instr_valid = 1'b0;
      chk("ready_back", 32'(instr_ready), 1);
      chk("done_clr", 32'(done), 0);
      chk("vec_idle", 32'(obs_v), 32'(IDLE_V));
   endtask

   initial begin
      int op;
      int cnt;
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instrucao   = '0;
      mul_count   = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_vec", 32'(obs_v), 32'(IDLE_V));
      chk("rst_ready", 32'(instr_ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      reset_n = 1'b1;
      @(negedge clock);

      run_instr(1, 0);
      run_instr(0, 5);
      run_instr(2, 0);
      run_instr(3, 0);
      run_instr(4, 0);
      run_instr(5, 9);
      run_instr(7, 2);
      run_instr(6, 3);
      run_instr(6, 0);
      run_instr(6, 15);

      for (int i = 0; i < 40; i++) begin
         op  = $urandom_range(0, 7);
         cnt = $urandom_range(0, 15);
         run_instr(op, cnt);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clock);
            chk("gap_ready", 32'(instr_ready), 1);
         end
      end

      op          = MUL_ON ? 6 : 5;
      instr_valid = 1'b1;
      instrucao   = 3'(op);
      mul_count   = 4'd8;
      @(posedge clock);
      instr_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      chk("abort_vec", 32'(obs_v), 32'(IDLE_V));
      chk("abort_ready", 32'(instr_ready), 1);
      chk("abort_done", 32'(done), 0);
      chk("abort_err", 32'(err), 0);
      reset_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clock);
         chk("abort_quiet", 32'(done), 0);
      end

      run_instr(1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
